pc_sequencer: RTL and testbench

- Parametrised successor to the combinational next-PC logic. Owns the architectural PC register and computes the next PC for sequential, branch, absolute-jump and register-jump flow.
- Adds stall hold, deferred redirect (a redirect that arrives while stalled is captured and applied on release), and a sticky misalignment flag.
- Sits between the control unit / comparator and the instruction-memory address port of the CPU.

---
 rtl/pc_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_pc_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the architectural PC and selects the next fetch address
// from sequential, branch, absolute-jump and register-jump flow.
// A redirect that arrives while stalled is captured and applied on release.
// A sticky flag records that the PC was ever loaded with a misaligned value.
// Optional return-address stack: define PC_SEQ_RAS_EN to enable it.
module pc_sequencer #(
    parameter int unsigned WIDTH     = 32,
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             branch,
    input  logic [WIDTH-1:0] imm,
    input  logic [1:0]       jump,
    input  logic [25:0]      addr26,
    input  logic [WIDTH-1:0] jr_target,
    input  logic             is_call,
    input  logic             is_ret,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_add_4,
    output logic [WIDTH-1:0] pc_link,
    output logic             redirect_pending,
    output logic             misalign
);

    localparam logic [WIDTH-1:0] RESET_PC_W = WIDTH'(RESET_PC);

    // IDLE: normal flow. HELD: a redirect was captured during a stall.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HELD = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] stored_q, stored_d;
    logic             misalign_q, misalign_d;

    logic             jmp_abs;
    logic             jmp_reg;
    logic             redirect;
    logic [WIDTH-1:0] br_off;
    logic [WIDTH-1:0] br_t;
    logic [WIDTH-1:0] j_t;
    logic [WIDTH-1:0] jr_t;
    logic [WIDTH-1:0] sel_target;
    logic             pc_load;
    logic             accept;

    // Code 3 on jump is reserved and behaves like "no jump".
    assign jmp_abs  = (jump == 2'd1);
    assign jmp_reg  = (jump == 2'd2);
    assign redirect = jmp_abs | jmp_reg | branch;

    assign pc_add_4 = pc_q + WIDTH'(4);
    assign pc_link  = pc_q + WIDTH'(8);
    assign br_off   = imm << 2;
    assign br_t     = pc_add_4 + br_off;
    assign j_t      = {pc_add_4[WIDTH-1:28], addr26, 2'b00};

    // A fresh redirect is consumed only when the sequencer is not already
    // holding one: either it loads the PC now or it is captured for later.
    assign accept = (state_q == ST_IDLE) & (~stall | redirect);

`ifdef PC_SEQ_RAS_EN
    localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

    // Circular stack; ras_ptr_q points at the next free slot, which is also
    // the oldest entry once the stack is full, so a push overwrites it.
    logic [WIDTH-1:0] ras_q [RAS_DEPTH];
    logic [PTR_W-1:0] ras_ptr_q, ras_ptr_d;
    logic [CNT_W-1:0] ras_cnt_q, ras_cnt_d;
    logic [PTR_W-1:0] ras_top_idx;
    logic [PTR_W-1:0] ras_wr_idx;
    logic             ras_pop_ok;
    logic             ras_do_pop;
    logic             ras_do_push;

    assign ras_top_idx = ras_ptr_q - 1'b1;
    assign ras_pop_ok  = is_ret & jmp_reg & (ras_cnt_q != '0);
    assign ras_do_pop  = accept & ras_pop_ok;
    assign ras_do_push = accept & is_call & (jmp_abs | jmp_reg);
    // Pop-then-push reuses the slot that was just popped.
    assign ras_wr_idx  = ras_do_pop ? ras_top_idx : ras_ptr_q;
    assign jr_t        = ras_pop_ok ? ras_q[ras_top_idx] : jr_target;

    // Stack pointer and occupancy update for pop, push, or both.
    always_comb begin
        ras_ptr_d = ras_ptr_q;
        ras_cnt_d = ras_cnt_q;
        if (ras_do_pop && ras_do_push) begin
            ras_ptr_d = ras_ptr_q;
            ras_cnt_d = ras_cnt_q;
        end else if (ras_do_pop) begin
            ras_ptr_d = ras_ptr_q - 1'b1;
            ras_cnt_d = ras_cnt_q - 1'b1;
        end else if (ras_do_push) begin
            ras_ptr_d = ras_ptr_q + 1'b1;
            if (ras_cnt_q != CNT_W'(RAS_DEPTH)) begin
                ras_cnt_d = ras_cnt_q + 1'b1;
            end
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            ras_ptr_q <= '0;
            ras_cnt_q <= '0;
        end else begin
            ras_ptr_q <= ras_ptr_d;
            ras_cnt_q <= ras_cnt_d;
        end
    end

    // Return-address storage; contents are don't-care until pushed.
    always_ff @(posedge clk) begin
        if (!reset && ras_do_push) begin
            ras_q[ras_wr_idx] <= pc_link;
        end
    end
`else
    logic unused_ras_inputs;
    assign unused_ras_inputs = is_call ^ is_ret;
    assign jr_t = jr_target;
`endif

    // Target selection: jump beats branch, branch beats sequential.
    always_comb begin
        sel_target = pc_add_4;
        if (jmp_abs) begin
            sel_target = j_t;
        end else if (jmp_reg) begin
            sel_target = jr_t;
        end else if (branch) begin
            sel_target = br_t;
        end
    end

    // Next-state and PC-update decisions for the stall/redirect handshake.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        stored_d = stored_q;
        pc_load  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!stall) begin
                    pc_d    = sel_target;
                    pc_load = 1'b1;
                end else if (redirect) begin
                    stored_d = sel_target;
                    state_d  = ST_HELD;
                end
            end
            ST_HELD: begin
                // Inputs this cycle are ignored; the first redirect wins.
                if (!stall) begin
                    pc_d    = stored_q;
                    pc_load = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        misalign_d = misalign_q | (pc_load & (pc_d[1:0] != 2'b00));
    end

    // State, PC, captured target and sticky misalignment registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC_W;
            stored_q   <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            stored_q   <= stored_d;
            misalign_q <= misalign_d;
        end
    end

    assign pc               = pc_q;
    assign redirect_pending = (state_q == ST_HELD);
    assign misalign         = misalign_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed walk through the key scenarios, then
// randomized stimulus compared every cycle against a behavioural model.
module tb_pc_sequencer;

    localparam int unsigned RAS_DEPTH = 4;
    localparam logic [31:0] RESET_PC  = 32'h0000_3000;

    logic        clk;
    logic        reset_r;
    logic        stall_r;
    logic        branch_r;
    logic [31:0] imm_r;
    logic [1:0]  jump_r;
    logic [25:0] addr26_r;
    logic [31:0] jr_r;
    logic        is_call_r;
    logic        is_ret_r;
    logic [31:0] pc_o;
    logic [31:0] pc_add_4_o;
    logic [31:0] pc_link_o;
    logic        pending_o;
    logic        misalign_o;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_stored;
    bit          m_pend;
    bit          m_mis;
    logic [31:0] m_ras[$];

    pc_sequencer #(
        .WIDTH(32),
        .RESET_PC(RESET_PC),
        .RAS_DEPTH(RAS_DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset_r),
        .stall(stall_r),
        .branch(branch_r),
        .imm(imm_r),
        .jump(jump_r),
        .addr26(addr26_r),
        .jr_target(jr_r),
        .is_call(is_call_r),
        .is_ret(is_ret_r),
        .pc(pc_o),
        .pc_add_4(pc_add_4_o),
        .pc_link(pc_link_o),
        .redirect_pending(pending_o),
        .misalign(misalign_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance the model by one clock using the currently driven inputs.
    task automatic model_step();
        logic [31:0] a4;
        logic [31:0] tgt;
        bit          redir;
        bit          pop_ok;
        a4 = m_pc + 32'd4;
        if (reset_r) begin
            m_pc = RESET_PC;
            m_pend = 0;
            m_mis = 0;
            m_stored = 32'd0;
            m_ras.delete();
            return;
        end
        if (m_pend) begin
            if (!stall_r) begin
                m_pc = m_stored;
                m_pend = 0;
                if (m_pc[1:0] != 2'b00) m_mis = 1;
            end
            return;
        end
        redir = (jump_r == 2'd1) || (jump_r == 2'd2) || branch_r;
        pop_ok = 0;
`ifdef PC_SEQ_RAS_EN
        pop_ok = is_ret_r && (jump_r == 2'd2) && (m_ras.size() > 0);
`endif
        if (jump_r == 2'd1)      tgt = {a4[31:28], addr26_r, 2'b00};
        else if (jump_r == 2'd2) tgt = pop_ok ? m_ras[$] : jr_r;
        else if (branch_r)       tgt = a4 + imm_r * 32'd4;
        else                     tgt = a4;
        if (stall_r && !redir) return;
`ifdef PC_SEQ_RAS_EN
        if (pop_ok) void'(m_ras.pop_back());
        if (is_call_r && (jump_r == 2'd1 || jump_r == 2'd2)) begin
            m_ras.push_back(m_pc + 32'd8);
            if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
        end
`endif
        if (stall_r) begin
            m_stored = tgt;
            m_pend = 1;
        end else begin
            m_pc = tgt;
            if (tgt[1:0] != 2'b00) m_mis = 1;
        end
    endtask

    // One clock transaction: model update, edge, then compare all outputs.
    task automatic step(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check({tag, ".pc"}, pc_o, m_pc);
        check({tag, ".add4"}, pc_add_4_o, m_pc + 32'd4);
        check({tag, ".link"}, pc_link_o, m_pc + 32'd8);
        check({tag, ".pend"}, {31'd0, pending_o}, {31'd0, m_pend});
        check({tag, ".mis"}, {31'd0, misalign_o}, {31'd0, m_mis});
        $display("[%0t] %s rst=%b stl=%b br=%b j=%0d call=%b ret=%b -> pc=%h pend=%b mis=%b",
                 $time, tag, reset_r, stall_r, branch_r, jump_r, is_call_r, is_ret_r,
                 pc_o, pending_o, misalign_o);
    endtask

    task automatic idle_inputs();
        reset_r = 0; stall_r = 0; branch_r = 0; imm_r = 32'd0; jump_r = 2'd0;
        addr26_r = 26'd0; jr_r = 32'd0; is_call_r = 0; is_ret_r = 0;
    endtask

    initial begin
        m_pc = 32'd0; m_stored = 32'd0; m_pend = 0; m_mis = 0;
        idle_inputs();
        reset_r = 1;
        step("reset");
        check("reset_pc", pc_o, 32'h0000_3000);
        check("reset_add4", pc_add_4_o, 32'h0000_3004);
        check("reset_link", pc_link_o, 32'h0000_3008);
        check("reset_mis", {31'd0, misalign_o}, 32'd0);

        idle_inputs();
        for (int i = 0; i < 3; i++) step("seq");
        check("seq3_pc", pc_o, 32'h0000_300C);
        step("seq");

        branch_r = 1; imm_r = 32'hFFFF_FFFC;
        step("branch");
        check("branch_pc", pc_o, 32'h0000_3004);
        idle_inputs();
        for (int i = 0; i < 3; i++) step("seq");
        check("seq_back_pc", pc_o, 32'h0000_3010);
        branch_r = 1; imm_r = 32'hFFFF_FFFC; jump_r = 2'd1; addr26_r = 26'h000_0C10;
        step("jump_vs_branch");
        check("jump_wins_pc", pc_o, 32'h0000_3040);

        idle_inputs();
        stall_r = 1; jump_r = 2'd2; jr_r = 32'h0000_3100;
        step("stall_capture");
        check("stall_hold_pc", pc_o, 32'h0000_3040);
        check("stall_pend", {31'd0, pending_o}, 32'd1);
        jr_r = 32'h0000_3200;
        step("stall_second");
        check("second_ignored_pc", pc_o, 32'h0000_3040);
        stall_r = 0; jr_r = 32'h0000_3300;
        step("release");
        check("release_pc", pc_o, 32'h0000_3100);
        check("release_pend", {31'd0, pending_o}, 32'd0);

        idle_inputs();
        jump_r = 2'd2; jr_r = 32'h0000_3102;
        step("misalign_jr");
        check("misalign_pc", pc_o, 32'h0000_3102);
        check("misalign_set", {31'd0, misalign_o}, 32'd1);
        jr_r = 32'h0000_3200;
        step("aligned_jr");
        check("misalign_sticky", {31'd0, misalign_o}, 32'd1);

        idle_inputs();
        stall_r = 1; jump_r = 2'd1; addr26_r = 26'h000_0D00;
        step("capture_before_reset");
        check("capture_pend", {31'd0, pending_o}, 32'd1);
        reset_r = 1;
        step("reset_pending");
        check("reset_pend_pc", pc_o, 32'h0000_3000);
        check("reset_pend_clear", {31'd0, pending_o}, 32'd0);
        check("reset_mis_clear", {31'd0, misalign_o}, 32'd0);

`ifdef PC_SEQ_RAS_EN
        idle_inputs();
        jump_r = 2'd1; is_call_r = 1; addr26_r = 26'h000_0C20;
        step("jal");
        check("jal_pc", pc_o, 32'h0000_3080);
        idle_inputs();
        jump_r = 2'd2; is_ret_r = 1; jr_r = 32'd0;
        step("ret");
        check("ret_pc", pc_o, 32'h0000_3008);

        idle_inputs();
        reset_r = 1;
        step("reset_ras");
        for (int k = 0; k < 5; k++) begin
            idle_inputs();
            jump_r = 2'd1; is_call_r = 1;
            addr26_r = 26'((32'h0000_3100 + 32'(k) * 32'h100) >> 2);
            step("call");
        end
        for (int k = 0; k < 5; k++) begin
            idle_inputs();
            jump_r = 2'd2; is_ret_r = 1; jr_r = 32'h0000_5000;
            step("return");
            if (k < 4) check("ras_lifo_pc", pc_o, 32'h0000_3408 - 32'(k) * 32'h100);
            else       check("ras_empty_pc", pc_o, 32'h0000_5000);
        end
`endif

        // Randomized phase
        for (int n = 0; n < 2000; n++) begin
            reset_r   = ($urandom_range(0, 49) == 0);
            stall_r   = ($urandom_range(0, 2) == 0);
            branch_r  = ($urandom_range(0, 3) == 0);
            imm_r     = 32'($urandom_range(0, 63)) - 32'd32;
            jump_r    = 2'($urandom_range(0, 3));
            addr26_r  = 26'($urandom);
            jr_r      = $urandom;
            if ($urandom_range(0, 7) != 0) jr_r[1:0] = 2'b00;
            is_call_r = ($urandom_range(0, 3) == 0);
            is_ret_r  = ($urandom_range(0, 3) == 0);
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
